wdb_entry_alloc: RTL and testbench
==================================

WDB_ENTRY_ALLOC -- requirements
Module: wdb_entry_alloc

Interface
REQ-001 The block SHALL have parameter CH_NUM, default 4, meaning the number of write channels, one per xbar output.
REQ-002 The block SHALL have parameter ENTRY_NUM, default 16, meaning write-data-buffer entries per channel.
REQ-003 The block SHALL have parameter IDX_WIDTH, default $clog2(ENTRY_NUM), meaning the entry index width, equal to DB_ENTRY_IDX_WIDTH.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset.
REQ-005 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 Port alloc_vld, output, CH_NUM bits: channel c has a free entry offered.
REQ-008 Port alloc_idx, output, IDX_WIDTH x [CH_NUM]: the offered entry index per channel.
REQ-009 Port alloc_rdy, input, CH_NUM bits: the consumer accepts the offered entry.
REQ-010 Port rel_vld, input, CH_NUM bits: release one entry on channel c.
REQ-011 Port rel_idx, input, IDX_WIDTH x [CH_NUM]: the index being released.
REQ-012 Port free_cnt, output, (IDX_WIDTH+1) x [CH_NUM]: the number of free entries per channel.
REQ-013 Port rel_err, output, CH_NUM bits: sticky flag for an illegal release.

Function
REQ-014 Each channel SHALL keep an independent ENTRY_NUM-bit free bitmap, where bit = 1 means the entry is free.
REQ-015 alloc_vld[c] SHALL be the OR of bitmap[c], driven combinationally from the registered bitmap.
REQ-016 alloc_idx[c] SHALL be the lowest-numbered free entry of bitmap[c], and SHALL be 0 when no entry is free.
REQ-017 An allocation SHALL occur on channel c in any cycle where alloc_vld[c] && alloc_rdy[c] is true; the entry is then cleared in the bitmap at the next edge.
REQ-018 alloc_rdy[c] with alloc_vld[c] = 0 SHALL have no effect.
REQ-019 Allocation latency: the next free index SHALL appear on alloc_idx[c] in the cycle after an allocation.
REQ-020 The same index SHALL never be presented as allocated twice before its release.
REQ-021 A release with rel_vld[c] = 1 SHALL set bitmap[c][rel_idx[c]] at the next edge; the entry is allocatable from the following cycle, and there is no bypass to the same cycle.
REQ-022 An illegal release SHALL be ignored, leave the bitmap unchanged, and set rel_err[c], which stays set until reset. A release is illegal if:
- the entry is already free, or
- rel_idx[c] >= ENTRY_NUM.
REQ-023 A simultaneous allocation and legal release on the same channel SHALL both apply in the same edge.
REQ-024 If the released index equals the index being allocated in that cycle, the release SHALL be illegal, because the entry is still free at that edge; it follows REQ-022 and the allocation proceeds.
REQ-025 free_cnt[c] SHALL be a registered count updated as count - alloc + legal release, and SHALL never exceed ENTRY_NUM or go below 0.
REQ-026 free_cnt[c] SHALL equal the popcount of bitmap[c] at all times.
REQ-027 When the channel is full (free_cnt = 0), alloc_vld[c] SHALL be 0; a legal release in cycle t SHALL raise alloc_vld[c] in cycle t+1.
REQ-028 Channels SHALL be fully independent; activity on one channel SHALL never affect another.
REQ-029 There SHALL be no internal pipelining beyond the bitmap and counter registers; the block is fully throughput-1 per channel.

Reset
REQ-030 While rst = 1 at an edge, the block SHALL set:
- all bitmaps to all-ones,
- free_cnt = ENTRY_NUM,
- rel_err = 0.
REQ-031 After reset, outputs SHALL be alloc_vld = all ones and alloc_idx = 0 on every channel.
REQ-032 Reset SHALL override any allocation or release presented in the same cycle.
REQ-033 Reset asserted mid-operation SHALL return all entries to free, with no outstanding-entry tracking retained.

Verification
REQ-034 Back-to-back allocation: after reset, hold alloc_rdy[0] = 1 for 16 cycles -> alloc_idx[0] = 0,1,...,15 on consecutive cycles; in cycle 17 alloc_vld[0] = 0 and free_cnt[0] = 0; channels 1-3 are unchanged (free_cnt = 16).
REQ-035 Release while full: with channel 0 full, release index 5 -> the next cycle gives alloc_vld[0] = 1, alloc_idx[0] = 5, free_cnt[0] = 1.
REQ-036 Simultaneous allocate and release: channel 2 has free entries {3,7}; in one cycle allocate (idx 3) and release idx 9 -> the next cycle gives alloc_idx[2] = 7 and free_cnt[2] unchanged.
REQ-037 Double release: release idx 4 on channel 1 while entry 4 is already free -> rel_err[1] = 1 and stays set, the bitmap is unchanged, free_cnt[1] is unchanged, and a subsequent alloc still returns 0.
REQ-038 Reset mid-traffic: allocate 10 entries on every channel, then pulse rst together with alloc_rdy = 1 and rel_vld = 1 -> the next cycle gives free_cnt = 16, alloc_idx = 0 and rel_err = 0 on all channels.
REQ-039 Random soak: random alloc_rdy/rel_vld (releasing only allocated entries) for 10k cycles -> no index is allocated twice while outstanding, free_cnt always equals the popcount, and rel_err stays 0.

Source files
------------

// File: rtl/wdb_entry_alloc.sv
// Per-channel write-data-buffer entry allocator.
// Free bitmap per channel, lowest-free offer, registered free count, sticky release error.
module wdb_entry_alloc #(
    parameter int CH_NUM    = 4,
    parameter int ENTRY_NUM = 16,
    parameter int IDX_WIDTH = $clog2(ENTRY_NUM)
) (
    input  logic                                clk,
    input  logic                                rst,
    output logic [CH_NUM-1:0]                   alloc_vld,
    output logic [CH_NUM-1:0][IDX_WIDTH-1:0]    alloc_idx,
    input  logic [CH_NUM-1:0]                   alloc_rdy,
    input  logic [CH_NUM-1:0]                   rel_vld,
    input  logic [CH_NUM-1:0][IDX_WIDTH-1:0]    rel_idx,
    output logic [CH_NUM-1:0][IDX_WIDTH:0]      free_cnt,
    output logic [CH_NUM-1:0]                   rel_err
);

    localparam int CW = IDX_WIDTH + 1;

    logic [CH_NUM-1:0][ENTRY_NUM-1:0] bitmap_q, bitmap_d;
    logic [CH_NUM-1:0][CW-1:0]        cnt_q, cnt_d;
    logic [CH_NUM-1:0]                err_q, err_d;
    logic [CH_NUM-1:0]                alloc_fire;
    logic [CH_NUM-1:0]                rel_in_range;
    logic [CH_NUM-1:0]                rel_ok;
    logic [CH_NUM-1:0]                rel_bad;

    // Downward scan so the last hit is the lowest free entry.
    always_comb begin
        alloc_idx = '0;
        alloc_vld = '0;
        for (int c = 0; c < CH_NUM; c++) begin
            alloc_vld[c] = |bitmap_q[c];
            for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
                if (bitmap_q[c][i]) begin
                    alloc_idx[c] = IDX_WIDTH'(i);
                end
            end
        end
    end

    // A release of a still-free entry (including the one being allocated now) is illegal.
    always_comb begin
        alloc_fire   = alloc_vld & alloc_rdy;
        rel_in_range = '0;
        rel_ok       = '0;
        rel_bad      = '0;
        for (int c = 0; c < CH_NUM; c++) begin
            rel_in_range[c] = {1'b0, rel_idx[c]} < CW'(ENTRY_NUM);
            if (rel_vld[c]) begin
                if (rel_in_range[c] && !bitmap_q[c][rel_idx[c]]) begin
                    rel_ok[c] = 1'b1;
                end else begin
                    rel_bad[c] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        bitmap_d = bitmap_q;
        cnt_d    = cnt_q;
        err_d    = err_q | rel_bad;
        for (int c = 0; c < CH_NUM; c++) begin
            if (alloc_fire[c]) begin
                bitmap_d[c][alloc_idx[c]] = 1'b0;
            end
            if (rel_ok[c]) begin
                bitmap_d[c][rel_idx[c]] = 1'b1;
            end
            cnt_d[c] = cnt_q[c] - CW'(alloc_fire[c]) + CW'(rel_ok[c]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bitmap_q <= '1;
            err_q    <= '0;
            for (int c = 0; c < CH_NUM; c++) begin
                cnt_q[c] <= CW'(ENTRY_NUM);
            end
        end else begin
            bitmap_q <= bitmap_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

    assign free_cnt = cnt_q;
    assign rel_err  = err_q;

endmodule

// File: tb/tb_wdb_entry_alloc.sv
// Scoreboard bench for wdb_entry_alloc: directed vectors plus a random soak
// against an outstanding-set model.
module tb_wdb_entry_alloc;

    localparam int CH = 4;
    localparam int EN = 16;
    localparam int IW = 4;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [CH-1:0]          alloc_vld;
    logic [CH-1:0][IW-1:0]  alloc_idx;
    logic [CH-1:0]          alloc_rdy;
    logic [CH-1:0]          rel_vld;
    logic [CH-1:0][IW-1:0]  rel_idx;
    logic [CH-1:0][IW:0]    free_cnt;
    logic [CH-1:0]          rel_err;

    wdb_entry_alloc #(.CH_NUM(CH), .ENTRY_NUM(EN), .IDX_WIDTH(IW)) dut (
        .clk       (clk),
        .rst       (rst),
        .alloc_vld (alloc_vld),
        .alloc_idx (alloc_idx),
        .alloc_rdy (alloc_rdy),
        .rel_vld   (rel_vld),
        .rel_idx   (rel_idx),
        .free_cnt  (free_cnt),
        .rel_err   (rel_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string name;
        int    ch;
        int    kind;
        int    val;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // kind: 0 alloc_vld, 1 alloc_idx, 2 free_cnt, 3 rel_err
    task automatic push_exp(input string nm, input int ch, input int kind, input int val);
        exp_t e;
        e.name = nm;
        e.ch   = ch;
        e.kind = kind;
        e.val  = val;
        q.push_back(e);
    endtask

    task automatic exp_ch(input string nm, input int ch, input int vld,
                          input int idx, input int cnt, input int err);
        push_exp({nm, ".vld"}, ch, 0, vld);
        push_exp({nm, ".idx"}, ch, 1, idx);
        push_exp({nm, ".cnt"}, ch, 2, cnt);
        push_exp({nm, ".err"}, ch, 3, err);
    endtask

    // Monitor: outputs for the current cycle are settled by the falling edge.
    always @(negedge clk) begin
        exp_t e;
        int   act;
        while (q.size() > 0) begin
            e = q.pop_front();
            case (e.kind)
                0:       act = int'(alloc_vld[e.ch]);
                1:       act = int'(alloc_idx[e.ch]);
                2:       act = int'(free_cnt[e.ch]);
                default: act = int'(rel_err[e.ch]);
            endcase
            n_chk++;
            if (act != e.val) begin
                n_fail++;
                $display("FAIL %s ch%0d: got %0d expected %0d", e.name, e.ch, act, e.val);
            end
        end
    end

    task automatic drive(input logic r, input logic [CH-1:0] rdy,
                         input logic [CH-1:0] rv, input logic [CH-1:0][IW-1:0] ri);
        @(posedge clk);
        #1;
        rst       = r;
        alloc_rdy = rdy;
        rel_vld   = rv;
        rel_idx   = ri;
    endtask

    logic [CH-1:0][IW-1:0] ri;
    logic [CH-1:0][EN-1:0] outst;
    logic [CH-1:0]         s_rdy, s_rv;
    logic [CH-1:0][IW-1:0] s_ri;

    initial begin
        rst       = 1'b1;
        alloc_rdy = '0;
        rel_vld   = '0;
        rel_idx   = '0;
        drive(1'b1, '0, '0, '0);
        drive(1'b1, '0, '0, '0);
        drive(1'b0, '0, '0, '0);
        for (int c = 0; c < CH; c++) exp_ch("reset", c, 1, 0, 16, 0);

        // back-to-back allocation on channel 0
        for (int k = 0; k < 16; k++) begin
            drive(1'b0, 4'b0001, '0, '0);
            exp_ch("b2b", 0, 1, k, 16 - k, 0);
        end
        drive(1'b0, '0, '0, '0);
        exp_ch("full", 0, 0, 0, 0, 0);
        for (int c = 1; c < CH; c++) exp_ch("b2b_other", c, 1, 0, 16, 0);

        // release while full; alloc_rdy without alloc_vld is ignored
        ri = '0;
        ri[0] = 4'd5;
        drive(1'b0, 4'b0001, 4'b0001, ri);
        exp_ch("rel_full_pre", 0, 0, 0, 0, 0);
        drive(1'b0, '0, '0, '0);
        exp_ch("rel_full", 0, 1, 5, 1, 0);

        // double release on channel 1
        ri = '0;
        ri[1] = 4'd4;
        drive(1'b0, '0, 4'b0010, ri);
        exp_ch("dbl_pre", 1, 1, 0, 16, 0);
        drive(1'b0, 4'b0010, '0, '0);
        exp_ch("dbl_err", 1, 1, 0, 16, 1);
        drive(1'b0, '0, '0, '0);
        exp_ch("dbl_alloc", 1, 1, 1, 15, 1);
        exp_ch("dbl_indep", 0, 1, 5, 1, 0);

        // channel 2: fill, free {3,7}, then alloc 3 with release 9
        for (int k = 0; k < 16; k++) drive(1'b0, 4'b0100, '0, '0);
        ri = '0;
        ri[2] = 4'd3;
        drive(1'b0, '0, 4'b0100, ri);
        exp_ch("ch2_full", 2, 0, 0, 0, 0);
        ri[2] = 4'd7;
        drive(1'b0, '0, 4'b0100, ri);
        exp_ch("ch2_one", 2, 1, 3, 1, 0);
        ri[2] = 4'd9;
        drive(1'b0, 4'b0100, 4'b0100, ri);
        exp_ch("ch2_two", 2, 1, 3, 2, 0);
        drive(1'b0, '0, '0, '0);
        exp_ch("alloc_rel", 2, 1, 7, 2, 0);

        // release of the index being allocated in the same cycle
        ri = '0;
        drive(1'b0, 4'b1000, 4'b1000, ri);
        exp_ch("same_pre", 3, 1, 0, 16, 0);
        drive(1'b0, '0, '0, '0);
        exp_ch("same_idx", 3, 1, 1, 15, 1);

        // reset mid-traffic
        drive(1'b1, '0, '0, '0);
        for (int k = 0; k < 10; k++) drive(1'b0, 4'hF, '0, '0);
        drive(1'b0, '0, '0, '0);
        for (int c = 0; c < CH; c++) exp_ch("ten", c, 1, 10, 6, 0);
        for (int c = 0; c < CH; c++) ri[c] = 4'd3;
        drive(1'b1, 4'hF, 4'hF, ri);
        drive(1'b0, '0, '0, '0);
        for (int c = 0; c < CH; c++) exp_ch("rst_mid", c, 1, 0, 16, 0);

        // random soak
        outst = '0;
        for (int n = 0; n < 10000; n++) begin
            s_rdy = '0;
            s_rv  = '0;
            s_ri  = '0;
            for (int c = 0; c < CH; c++) begin
                int start;
                s_rdy[c] = ($urandom_range(0, 3) != 0);
                start    = $urandom_range(0, EN - 1);
                if ($urandom_range(0, 1) == 1) begin
                    for (int j = 0; j < EN; j++) begin
                        int x;
                        x = (start + j) % EN;
                        if (!s_rv[c] && outst[c][x]) begin
                            s_rv[c] = 1'b1;
                            s_ri[c] = IW'(x);
                        end
                    end
                end
            end
            drive(1'b0, s_rdy, s_rv, s_ri);
            for (int c = 0; c < CH; c++) begin
                int cnt;
                int low;
                cnt = EN;
                low = -1;
                for (int i = 0; i < EN; i++) begin
                    if (outst[c][i]) cnt--;
                    else if (low < 0) low = i;
                end
                exp_ch("soak", c, (cnt > 0) ? 1 : 0, (low < 0) ? 0 : low, cnt, 0);
                if (s_rdy[c] && low >= 0) outst[c][low] = 1'b1;
                if (s_rv[c]) outst[c][s_ri[c]] = 1'b0;
            end
        end

        drive(1'b0, '0, '0, '0);
        @(negedge clk);
        #1;
        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
